// File: rtl/cl2_csr_reg_pkg.sv
// rtl/cl2_csr_reg_pkg.sv - CSR addresses, interrupt codes, mstatus layout and trap FSM states
package cl2_csr_reg_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam logic [4:0] IRQ_MSI = 5'd3;
    localparam logic [4:0] IRQ_MTI = 5'd7;
    localparam logic [4:0] IRQ_MEI = 5'd11;

    localparam int MSTATUS_MIE_BIT = 3;

    typedef struct packed {
        logic [18:0] upper;
        logic [1:0]  mpp;
        logic [2:0]  rsv_10_8;
        logic        mpie;
        logic [2:0]  rsv_6_4;
        logic        mie;
        logic [2:0]  rsv_2_0;
    } cl2_csr_mstatus_reg_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_MEPC,
        ST_W_MCAUSE,
        ST_W_MTVAL,
        ST_W_MSTAT,
        ST_W_MRET,
        ST_REDIR
    } trap_state_e;

endpackage

// File: rtl/cl2_irq_prio.sv
// rtl/cl2_irq_prio.sv - machine interrupt priority encoder, MEI > MSI > MTI
module cl2_irq_prio
    import cl2_csr_reg_pkg::*;
(
    input  logic [31:0] mip_i,
    input  logic [31:0] mie_i,
    input  logic        global_ie_i,
    output logic        irq_valid_o,
    output logic [4:0]  irq_cause_o
);

    logic [31:0] pend;
    logic        unused_pend;

    assign pend        = mip_i & mie_i;
    assign unused_pend = ^{pend[31:12], pend[10:8], pend[6:4], pend[2:0]};

    always_comb begin
        irq_valid_o = global_ie_i;
        irq_cause_o = '0;
        if (pend[IRQ_MEI]) begin
            irq_cause_o = IRQ_MEI;
        end else if (pend[IRQ_MSI]) begin
            irq_cause_o = IRQ_MSI;
        end else if (pend[IRQ_MTI]) begin
            irq_cause_o = IRQ_MTI;
        end else begin
            irq_valid_o = 1'b0;
        end
    end

endmodule

// File: rtl/cl2_csr_trap_ctrl.sv
// rtl/cl2_csr_trap_ctrl.sv - machine-mode trap/MRET sequencer driving the CSR write port and fetch redirect
module cl2_csr_trap_ctrl
    import cl2_csr_reg_pkg::*;
#(
    parameter bit MTVAL_EN = 1'b1,
    parameter bit VEC_EN   = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        exc_valid_i,
    input  logic [4:0]  exc_cause_i,
    input  logic [31:0] exc_pc_i,
    input  logic [31:0] exc_tval_i,
    input  logic        mret_valid_i,
    input  logic [31:0] intr_pc_i,
    input  logic [31:0] mstatus_i,
    input  logic [31:0] mie_i,
    input  logic [31:0] mip_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    output logic        trap_ack_o,
    output logic        busy_o,
    output logic        csr_we_o,
    output logic [11:0] csr_waddr_o,
    output logic [31:0] csr_wdata_o,
    input  logic        csr_wready_i,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o
);

    trap_state_e          state_q, state_d;
    logic                 irq_valid;
    logic [4:0]           irq_cause;
    logic                 accept, take_mret, take_irq;
    logic [31:0]          pc_q, tval_q, mtvec_q, mepc_q;
    logic [4:0]           cause_q;
    logic                 irq_q, mret_q;
    cl2_csr_mstatus_reg_t mstatus_q, trap_mstatus, mret_mstatus;
    logic [31:0]          trap_target;

    cl2_irq_prio u_irq_prio (
        .mip_i       (mip_i),
        .mie_i       (mie_i),
        .global_ie_i (mstatus_i[MSTATUS_MIE_BIT]),
        .irq_valid_o (irq_valid),
        .irq_cause_o (irq_cause)
    );

    assign take_mret = !exc_valid_i && mret_valid_i;
    assign take_irq  = !exc_valid_i && !mret_valid_i && irq_valid;
    assign accept    = (state_q == ST_IDLE) && !rst_i && (exc_valid_i || mret_valid_i || irq_valid);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Everything the sequence needs is captured at accept; later CSR/input changes are ignored.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            pc_q      <= exc_valid_i ? exc_pc_i : intr_pc_i;
            cause_q   <= exc_valid_i ? exc_cause_i : irq_cause;
            tval_q    <= exc_valid_i ? exc_tval_i : 32'h0;
            irq_q     <= take_irq;
            mret_q    <= take_mret;
            mstatus_q <= cl2_csr_mstatus_reg_t'(mstatus_i);
            mtvec_q   <= mtvec_i;
            mepc_q    <= mepc_i;
        end
    end

    always_comb begin
        trap_mstatus      = mstatus_q;
        trap_mstatus.mpie = mstatus_q.mie;
        trap_mstatus.mie  = 1'b0;
        trap_mstatus.mpp  = 2'b11;
        mret_mstatus      = mstatus_q;
        mret_mstatus.mie  = mstatus_q.mpie;
        mret_mstatus.mpie = 1'b1;
        mret_mstatus.mpp  = 2'b11;
        trap_target       = {mtvec_q[31:2], 2'b00};
        if (VEC_EN && irq_q && (mtvec_q[1:0] == 2'b01)) begin
            trap_target = {mtvec_q[31:2], 2'b00} + {25'b0, cause_q, 2'b00};
        end
    end

    always_comb begin
        state_d          = state_q;
        trap_ack_o       = 1'b0;
        busy_o           = (state_q != ST_IDLE);
        csr_we_o         = 1'b0;
        csr_waddr_o      = '0;
        csr_wdata_o      = '0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    trap_ack_o = 1'b1;
                    state_d    = take_mret ? ST_W_MRET : ST_W_MEPC;
                end
            end
            ST_W_MEPC: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MEPC;
                csr_wdata_o = {pc_q[31:2], 2'b00};
                if (csr_wready_i) state_d = ST_W_MCAUSE;
            end
            ST_W_MCAUSE: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MCAUSE;
                csr_wdata_o = {irq_q, 26'b0, cause_q};
                if (csr_wready_i) begin
                    if (MTVAL_EN) state_d = ST_W_MTVAL;
                    else          state_d = ST_W_MSTAT;
                end
            end
            ST_W_MTVAL: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MTVAL;
                csr_wdata_o = tval_q;
                if (csr_wready_i) state_d = ST_W_MSTAT;
            end
            ST_W_MSTAT: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MSTATUS;
                csr_wdata_o = trap_mstatus;
                if (csr_wready_i) state_d = ST_REDIR;
            end
            ST_W_MRET: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MSTATUS;
                csr_wdata_o = mret_mstatus;
                if (csr_wready_i) state_d = ST_REDIR;
            end
            ST_REDIR: begin
                redirect_valid_o = 1'b1;
                redirect_pc_o    = mret_q ? mepc_q : trap_target;
                state_d          = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cl2_csr_trap_ctrl.sv
// tb/tb_cl2_csr_trap_ctrl.sv - self-checking bench for cl2_csr_trap_ctrl
module tb_cl2_csr_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst_i, exc_valid_i, mret_valid_i, csr_wready_i;
    logic [4:0]  exc_cause_i;
    logic [31:0] exc_pc_i, exc_tval_i, intr_pc_i, mstatus_i, mie_i, mip_i, mtvec_i, mepc_i;
    logic        trap_ack_o, busy_o, csr_we_o, redirect_valid_o;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o, redirect_pc_o;

    always #5 clk = ~clk;

    cl2_csr_trap_ctrl #(.MTVAL_EN(1'b1), .VEC_EN(1'b1)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i), .exc_pc_i(exc_pc_i),
        .exc_tval_i(exc_tval_i), .mret_valid_i(mret_valid_i), .intr_pc_i(intr_pc_i),
        .mstatus_i(mstatus_i), .mie_i(mie_i), .mip_i(mip_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
        .trap_ack_o(trap_ack_o), .busy_o(busy_o), .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o),
        .csr_wdata_o(csr_wdata_o), .csr_wready_i(csr_wready_i),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o)
    );

    typedef struct {
        logic        exc;
        logic [4:0]  cause;
        logic [31:0] pc, tval;
        logic        mret;
        logic [31:0] intr_pc, mstatus, mie, mip, mtvec, mepc;
    } req_t;

    typedef struct {
        req_t        r;
        logic [31:0] exp_mcause;
        logic [31:0] exp_mstat;
        logic [31:0] exp_redir;
        int          exp_lat;
    } vec_t;

    localparam logic [31:0] NONE = 32'hFFFF_FFFF;

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] act_addr[$];
    logic [31:0] act_data[$];
    int          act_ack_n, act_redir_n, act_lat, act_stalls;
    logic [31:0] act_pc;

    logic [11:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] exp_pc;
    logic        exp_ack;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic req_t mk(input logic exc, input logic [4:0] cause, input logic [31:0] pc,
                                input logic [31:0] tval, input logic mret, input logic [31:0] intr_pc,
                                input logic [31:0] mstatus, input logic [31:0] mie, input logic [31:0] mip,
                                input logic [31:0] mtvec, input logic [31:0] mepc);
        req_t r;
        r.exc = exc; r.cause = cause; r.pc = pc; r.tval = tval; r.mret = mret; r.intr_pc = intr_pc;
        r.mstatus = mstatus; r.mie = mie; r.mip = mip; r.mtvec = mtvec; r.mepc = mepc;
        return r;
    endfunction

    // Reference: list of CSR writes and redirect target derived directly from the trap rules.
    function automatic void model(input req_t r);
        int          irq_code;
        int          code;
        logic [31:0] pend, m;
        logic        is_irq;
        exp_addr.delete();
        exp_data.delete();
        exp_pc   = 32'h0;
        irq_code = -1;
        pend     = r.mip & r.mie;
        m        = r.mstatus;
        if (m[3]) begin
            if (pend[11])     irq_code = 11;
            else if (pend[3]) irq_code = 3;
            else if (pend[7]) irq_code = 7;
        end
        exp_ack = r.exc || r.mret || (irq_code >= 0);
        if (r.exc || (!r.mret && irq_code >= 0)) begin
            is_irq = !r.exc;
            code   = is_irq ? irq_code : int'(r.cause);
            exp_addr.push_back(12'h341); exp_data.push_back((is_irq ? r.intr_pc : r.pc) & 32'hFFFF_FFFC);
            exp_addr.push_back(12'h342); exp_data.push_back((is_irq ? 32'h8000_0000 : 32'h0) + 32'(code));
            exp_addr.push_back(12'h343); exp_data.push_back(is_irq ? 32'h0 : r.tval);
            exp_addr.push_back(12'h300);
            exp_data.push_back((m & ~32'h1888) | (m[3] ? 32'h80 : 32'h0) | 32'h1800);
            exp_pc = r.mtvec & 32'hFFFF_FFFC;
            if (is_irq && r.mtvec[1:0] == 2'b01) exp_pc = exp_pc + 32'(code * 4);
        end else if (r.mret) begin
            exp_addr.push_back(12'h300);
            exp_data.push_back((m & ~32'h1888) | (m[7] ? 32'h8 : 32'h0) | 32'h80 | 32'h1800);
            exp_pc = r.mepc;
        end
    endfunction

    task automatic apply(input req_t r);
        exc_valid_i = r.exc;  exc_cause_i = r.cause; exc_pc_i = r.pc; exc_tval_i = r.tval;
        mret_valid_i = r.mret; intr_pc_i = r.intr_pc; mstatus_i = r.mstatus;
        mie_i = r.mie; mip_i = r.mip; mtvec_i = r.mtvec; mepc_i = r.mepc;
    endtask

    task automatic run_txn(input req_t r, input int stall_pct, input logic [11:0] stall_addr,
                           input int stall_n, input bit keep_mret);
        bit          done, holding, dropped;
        int          stalled, budget;
        logic [11:0] hold_a;
        logic [31:0] hold_d;
        act_addr.delete(); act_data.delete();
        act_ack_n = 0; act_redir_n = 0; act_lat = -1; act_stalls = 0; act_pc = 32'h0;
        done = 0; holding = 0; dropped = 0; stalled = 0;
        model(r);
        budget = exp_ack ? 40 : 4;
        @(negedge clk);
        apply(r);
        #1;
        check("idle_busy", 32'(busy_o), 32'h0);
        check("idle_redirect", 32'(redirect_valid_o), 32'h0);
        for (int cyc = 0; cyc < budget && !done; cyc++) begin
            if (cyc > 0) begin
                @(negedge clk);
                if (act_ack_n > 0 && !dropped) begin
                    // request released; scramble everything to show the snapshot is used
                    exc_valid_i = 1'b0; mret_valid_i = keep_mret; dropped = 1;
                    mip_i = 32'hFFFF_FFFF; mie_i = $urandom; mstatus_i = $urandom;
                    mtvec_i = $urandom; mepc_i = $urandom; exc_pc_i = $urandom;
                    exc_tval_i = $urandom; intr_pc_i = $urandom; exc_cause_i = 5'($urandom);
                end
                #1;
            end
            if (holding) begin
                check("stall_addr", 32'(csr_waddr_o), 32'(hold_a));
                check("stall_data", csr_wdata_o, hold_d);
                holding = 0;
            end
            if (trap_ack_o) act_ack_n++;
            if (redirect_valid_o) begin
                act_redir_n++; act_pc = redirect_pc_o; act_lat = cyc; done = 1;
                mip_i = 32'h0;
            end
            if (csr_we_o) begin
                if (csr_waddr_o == stall_addr && stalled < stall_n) begin
                    csr_wready_i = 1'b0; stalled++;
                end else begin
                    csr_wready_i = !(stall_pct > 0 && $urandom_range(99) < stall_pct);
                end
                if (csr_wready_i) begin
                    act_addr.push_back(csr_waddr_o); act_data.push_back(csr_wdata_o);
                end else begin
                    act_stalls++; holding = 1; hold_a = csr_waddr_o; hold_d = csr_wdata_o;
                end
            end else begin
                csr_wready_i = 1'($urandom);
            end
        end
    endtask

    task automatic verify(input string tag, input req_t r);
        int n;
        model(r);
        check({tag, "_ack"}, 32'(act_ack_n), exp_ack ? 32'd1 : 32'd0);
        check({tag, "_nwrites"}, 32'(act_addr.size()), 32'(exp_addr.size()));
        n = (act_addr.size() < exp_addr.size()) ? act_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_waddr%0d", tag, i), 32'(act_addr[i]), 32'(exp_addr[i]));
            check($sformatf("%s_wdata%0d", tag, i), act_data[i], exp_data[i]);
        end
        check({tag, "_redir_n"}, 32'(act_redir_n), exp_ack ? 32'd1 : 32'd0);
        if (exp_ack) begin
            check({tag, "_redir_pc"}, act_pc, exp_pc);
            check({tag, "_latency"}, 32'(act_lat), 32'(exp_addr.size() + 1 + act_stalls));
        end
    endtask

    function automatic logic [31:0] find_write(input logic [11:0] a);
        for (int i = 0; i < act_addr.size(); i++)
            if (act_addr[i] == a) return act_data[i];
        return NONE;
    endfunction

    vec_t vt[9];
    req_t r, r2;

    initial begin
        rst_i = 1'b1; csr_wready_i = 1'b1;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (3) @(negedge clk);
        #1;
        check("rst_ack", 32'(trap_ack_o), 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);
        check("rst_we", 32'(csr_we_o), 32'h0);
        check("rst_waddr", 32'(csr_waddr_o), 32'h0);
        check("rst_wdata", csr_wdata_o, 32'h0);
        check("rst_redir_valid", 32'(redirect_valid_o), 32'h0);
        check("rst_redir_pc", redirect_pc_o, 32'h0);
        rst_i = 1'b0;

        //            exc cause pc             tval         mret intr_pc        mstatus      mie          mip          mtvec          mepc
        vt[0].r = mk(1, 2,  32'h8000_0104, 32'h0000_DEAD, 0, 32'h0,        32'h8,       32'h0,       32'h0,       32'h8000_0000, 32'h0);
        vt[0].exp_mcause = 32'h2;         vt[0].exp_mstat = 32'h1880; vt[0].exp_redir = 32'h8000_0000; vt[0].exp_lat = 5;
        vt[1].r = mk(0, 0,  32'h0,         32'h0,         0, 32'h8000_0040, 32'h8,      32'h888,     32'h888,     32'h8000_0001, 32'h0);
        vt[1].exp_mcause = 32'h8000_000B; vt[1].exp_mstat = 32'h1880; vt[1].exp_redir = 32'h8000_002C; vt[1].exp_lat = 5;
        vt[2].r = mk(0, 0,  32'h0,         32'h0,         1, 32'h0,        32'h80,      32'h0,       32'h0,       32'h0,         32'h8000_0200);
        vt[2].exp_mcause = NONE;          vt[2].exp_mstat = 32'h1888; vt[2].exp_redir = 32'h8000_0200; vt[2].exp_lat = 2;
        vt[3].r = mk(0, 0,  32'h0,         32'h0,         0, 32'h1000,     32'h8,       32'h88,      32'h88,      32'h1000_0001, 32'h0);
        vt[3].exp_mcause = 32'h8000_0003; vt[3].exp_mstat = 32'h1880; vt[3].exp_redir = 32'h1000_000C; vt[3].exp_lat = 5;
        vt[4].r = mk(0, 0,  32'h0,         32'h0,         0, 32'h1000,     32'h0,       32'h800,     32'h800,     32'h1000_0001, 32'h0);
        vt[4].exp_mcause = NONE;          vt[4].exp_mstat = NONE;     vt[4].exp_redir = 32'h0;         vt[4].exp_lat = -1;
        vt[5].r = mk(0, 0,  32'h0,         32'h0,         0, 32'h2000,     32'hFFFF_FFFF, 32'h80,    32'h80,      32'h2000_0102, 32'h0);
        vt[5].exp_mcause = 32'h8000_0007; vt[5].exp_mstat = 32'hFFFF_FFF7; vt[5].exp_redir = 32'h2000_0100; vt[5].exp_lat = 5;
        vt[6].r = mk(1, 5,  32'h0000_1003, 32'h1234,      0, 32'h0,        32'h0,       32'h0,       32'h0,       32'h0000_4001, 32'h0);
        vt[6].exp_mcause = 32'h5;         vt[6].exp_mstat = 32'h1800; vt[6].exp_redir = 32'h0000_4000; vt[6].exp_lat = 5;
        vt[7].r = mk(0, 0,  32'h0,         32'h0,         0, 32'h3000,     32'h8,       32'h800,     32'h800,     32'hFFFF_FFF1, 32'h0);
        vt[7].exp_mcause = 32'h8000_000B; vt[7].exp_mstat = 32'h1880; vt[7].exp_redir = 32'h0000_001C; vt[7].exp_lat = 5;
        vt[8].r = mk(0, 0,  32'h0,         32'h0,         1, 32'h0,        32'h8,       32'h800,     32'h800,     32'h0,         32'h1234_5678);
        vt[8].exp_mcause = NONE;          vt[8].exp_mstat = 32'h1880; vt[8].exp_redir = 32'h1234_5678; vt[8].exp_lat = 2;

        for (int i = 0; i < 9; i++) begin
            run_txn(vt[i].r, 0, 12'h000, 0, 0);
            check($sformatf("vec%0d_mcause", i), find_write(12'h342), vt[i].exp_mcause);
            check($sformatf("vec%0d_mstatus", i), find_write(12'h300), vt[i].exp_mstat);
            check($sformatf("vec%0d_redir", i), act_pc, vt[i].exp_redir);
            check($sformatf("vec%0d_lat", i), 32'(act_lat), 32'(vt[i].exp_lat));
            verify($sformatf("vec%0d", i), vt[i].r);
        end

        // exception beats simultaneous MRET and MTI; held MRET taken once back in IDLE
        r = mk(1, 4, 32'h8000_0010, 32'h55, 1, 32'h8000_0014, 32'h8, 32'h80, 32'h80, 32'h8000_0000, 32'h8000_0300);
        run_txn(r, 0, 12'h000, 0, 1);
        check("arb_mcause", find_write(12'h342), 32'h4);
        verify("arb_exc", r);
        r2 = mk(0, 0, 32'h0, 32'h0, 1, 32'h0, 32'h80, 32'h80, 32'h80, 32'h0, 32'h8000_0300);
        run_txn(r2, 0, 12'h000, 0, 0);
        verify("arb_mret", r2);

        // CSR write port back-pressure in W_MCAUSE
        run_txn(vt[0].r, 0, 12'h342, 3, 0);
        check("stall_count", 32'(act_stalls), 32'd3);
        check("stall_latency", 32'(act_lat), 32'd8);
        verify("stall", vt[0].r);

        // reset in W_MTVAL aborts the sequence with no redirect
        @(negedge clk);
        apply(vt[0].r); csr_wready_i = 1'b1;
        #1;
        check("rstmid_ack", 32'(trap_ack_o), 32'h1);
        @(negedge clk); exc_valid_i = 1'b0; #1;
        check("rstmid_mepc", 32'(csr_waddr_o), 32'h341);
        @(negedge clk); #1;
        check("rstmid_mcause", 32'(csr_waddr_o), 32'h342);
        @(negedge clk); #1;
        check("rstmid_mtval", 32'(csr_waddr_o), 32'h343);
        rst_i = 1'b1;
        @(negedge clk); #1;
        check("rstmid_we", 32'(csr_we_o), 32'h0);
        check("rstmid_busy", 32'(busy_o), 32'h0);
        check("rstmid_redir", 32'(redirect_valid_o), 32'h0);
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("rstmid_after_redir", 32'(redirect_valid_o), 32'h0);
            check("rstmid_after_busy", 32'(busy_o), 32'h0);
        end

        for (int i = 0; i < 60; i++) begin
            r.exc     = ($urandom_range(99) < 30);
            r.cause   = 5'($urandom);
            r.pc      = $urandom;
            r.tval    = $urandom;
            r.mret    = ($urandom_range(99) < 25);
            r.intr_pc = $urandom;
            r.mstatus = $urandom;
            r.mie     = $urandom | (32'($urandom_range(7)) << 0) | 32'h888;
            r.mip     = ($urandom & 32'hFFFF_F777) | ($urandom_range(1) ? 32'h800 : 32'h0)
                      | ($urandom_range(1) ? 32'h8 : 32'h0) | ($urandom_range(1) ? 32'h80 : 32'h0);
            r.mtvec   = $urandom;
            r.mepc    = $urandom;
            run_txn(r, 30, 12'h000, 0, 0);
            verify($sformatf("rnd%0d", i), r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
